// File: rtl/rgb_to_byte_packer.sv
// rgb_to_byte_packer
// Packs 24-bit RGB pixels into 2-2-2 bytes with frame-buffer addresses,
// buffered through a two-entry output FIFO with valid/ready handshakes on
// both sides.
// Optional feature macro: RGB_TO_BYTE_ROUND_EN
//   defined   -> each 2-bit code is rounded: min(c[7:6] + c[5], 3)
//   undefined -> each 2-bit code is truncated to c[7:6]
module rgb_to_byte_packer #(
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480,
    parameter int unsigned ADDR_BITS = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           r_in,
    input  logic [7:0]           g_in,
    input  logic [7:0]           b_in,
    input  logic                 sof_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [7:0]           byte_out,
    output logic [ADDR_BITS-1:0] addr_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_done_out
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

`ifdef RGB_TO_BYTE_ROUND_EN
    // Rounded 2-bit code: top two bits plus the next bit, saturating at 3.
    function automatic logic [1:0] color_code(input logic [2:0] top_bits);
        logic [2:0] sum;
        sum = {1'b0, top_bits[2:1]} + {2'b00, top_bits[0]};
        if (sum[2]) begin
            color_code = 2'b11;
        end else begin
            color_code = sum[1:0];
        end
    endfunction
`else
    // Truncated 2-bit code: just the top two bits.
    function automatic logic [1:0] color_code(input logic [1:0] top_bits);
        color_code = top_bits;
    endfunction
`endif

    // Address counter and frame-done pulse state
    logic [ADDR_BITS-1:0] addr_cnt_r;
    logic                 frame_done_r;

    // Two-entry FIFO: head entry drives the outputs directly, tail is the spare slot
    logic [7:0]           head_byte_r;
    logic [ADDR_BITS-1:0] head_addr_r;
    logic                 head_valid_r;
    logic [7:0]           tail_byte_r;
    logic [ADDR_BITS-1:0] tail_addr_r;
    logic                 tail_valid_r;

    logic                 push_s;
    logic                 pop_s;
    logic [7:0]           new_byte_s;
    logic [ADDR_BITS-1:0] pixel_addr_s;
    logic [ADDR_BITS-1:0] next_addr_s;
    logic                 last_pixel_s;
    logic                 unused_bits_s;

`ifdef RGB_TO_BYTE_ROUND_EN
    assign unused_bits_s = ^{r_in[4:0], g_in[4:0], b_in[4:0]};
`else
    assign unused_bits_s = ^{r_in[5:0], g_in[5:0], b_in[5:0]};
`endif

    // Full means the tail slot is occupied; this depends on registered state only
    assign ready_out      = ~tail_valid_r;
    assign valid_out      = head_valid_r;
    assign byte_out       = head_byte_r;
    assign addr_out       = head_addr_r;
    assign frame_done_out = frame_done_r;

    // Handshakes, packed byte and address selection for the pixel on the input
    always_comb begin
        push_s       = valid_in & ready_out;
        pop_s        = head_valid_r & ready_in;
`ifdef RGB_TO_BYTE_ROUND_EN
        new_byte_s   = {2'b00, color_code(r_in[7:5]), color_code(g_in[7:5]),
                        color_code(b_in[7:5])};
`else
        new_byte_s   = {2'b00, color_code(r_in[7:6]), color_code(g_in[7:6]),
                        color_code(b_in[7:6])};
`endif
        if (sof_in) begin
            pixel_addr_s = ADDR_ZERO;
        end else begin
            pixel_addr_s = addr_cnt_r;
        end
        last_pixel_s = (pixel_addr_s == LAST_ADDR);
        if (last_pixel_s) begin
            next_addr_s = ADDR_ZERO;
        end else begin
            next_addr_s = pixel_addr_s + ADDR_ONE;
        end
    end

    // Address counter advances per accepted pixel; frame-done pulses after the last one
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_r   <= ADDR_ZERO;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= push_s & last_pixel_s;
            if (push_s) begin
                addr_cnt_r <= next_addr_s;
            end
        end
    end

    // FIFO update: fill head first, spill into tail, shift tail to head on pop
    always_ff @(posedge clk) begin
        if (reset) begin
            head_byte_r  <= 8'h00;
            head_addr_r  <= ADDR_ZERO;
            head_valid_r <= 1'b0;
            tail_byte_r  <= 8'h00;
            tail_addr_r  <= ADDR_ZERO;
            tail_valid_r <= 1'b0;
        end else if (!head_valid_r) begin
            if (push_s) begin
                head_byte_r  <= new_byte_s;
                head_addr_r  <= pixel_addr_s;
                head_valid_r <= 1'b1;
            end
        end else if (!pop_s) begin
            if (push_s) begin
                tail_byte_r  <= new_byte_s;
                tail_addr_r  <= pixel_addr_s;
                tail_valid_r <= 1'b1;
            end
        end else if (tail_valid_r) begin
            head_byte_r  <= tail_byte_r;
            head_addr_r  <= tail_addr_r;
            tail_valid_r <= push_s;
            if (push_s) begin
                tail_byte_r <= new_byte_s;
                tail_addr_r <= pixel_addr_s;
            end
        end else begin
            head_valid_r <= push_s;
            if (push_s) begin
                head_byte_r <= new_byte_s;
                head_addr_r <= pixel_addr_s;
            end
        end
    end

endmodule

// File: doc/rgb_to_byte_packer.md
RGB_TO_BYTE_PACKER -- requirements
Module: rgb_to_byte_packer

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line.
REQ-002 Parameter HEIGHT, default 480, lines per frame.
REQ-003 Parameter ADDR_BITS, default 19, frame-buffer address width; must satisfy 2**ADDR_BITS >= WIDTH*HEIGHT.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 r_in, g_in, b_in  input  8 each  upstream pixel colour components.
REQ-007 sof_in  input  1  marks the pixel in flight as the first pixel of a frame.
REQ-008 valid_in  input  1  upstream pixel valid.
REQ-009 ready_out  output  1  packer can accept a pixel.
REQ-010 byte_out  output  8  packed pixel byte.
REQ-011 addr_out  output  ADDR_BITS  frame-buffer address of byte_out.
REQ-012 valid_out  output  1  byte_out/addr_out valid.
REQ-013 ready_in  input  1  downstream accepts the byte.
REQ-014 frame_done_out  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-015 Input transfer when valid_in && ready_out on a rising edge; output transfer when valid_out && ready_in.
REQ-016 Packed format: byte[7:6]=2'b00, byte[5:4]=R code, byte[3:2]=G code, byte[1:0]=B code.
REQ-017 Without rounding, each 2-bit code is the component's bits [7:6].
REQ-018 A two-entry FIFO of {byte, addr} sits between the packer and the output; ready_out = (occupancy < 2), derived from registered occupancy only.
REQ-019 Latency: a pixel accepted into an empty FIFO appears on valid_out/byte_out on the next cycle.
REQ-020 Bytes leave in acceptance order; none dropped or duplicated.
REQ-021 Simultaneous push and pop: occupancy unchanged, and valid_out remains high.
REQ-022 When full, ready_out is low, and a pop in that cycle raises ready_out on the next cycle.
REQ-023 Address counter: each accepted pixel takes the current address; the counter then increments and wraps from WIDTH*HEIGHT-1 to 0.
REQ-024 An accepted pixel with sof_in=1 takes address 0, and the counter becomes 1.
REQ-025 sof_in without valid_in && ready_out has no effect.
REQ-026 frame_done_out pulses high for exactly one cycle, the cycle after a pixel assigned address WIDTH*HEIGHT-1 is accepted.
REQ-027 Outputs hold stable while valid_out && !ready_in.

Reset
REQ-028 While reset is high at a clock edge: FIFO emptied, address counter = 0, valid_out=0, frame_done_out=0, byte_out=0, addr_out=0, ready_out=1 the following cycle.
REQ-029 Reset mid-transfer discards all buffered bytes; the first pixel after reset takes address 0.

Configuration
REQ-030 Macro RGB_TO_BYTE_ROUND_EN selects rounding.
REQ-031 Defined: code = min(c[7:6] + c[5], 3) per component.
REQ-032 Undefined: truncation per REQ-017.

Verification
REQ-033 Reset, then push R=255, G=255, B=255 with ready_in=1 -> byte_out=8'b00111111, addr_out=0, valid_out one cycle later.
REQ-034 Push (0x40,0x80,0xC0) -> truncation gives 8'b00011011; with RGB_TO_BYTE_ROUND_EN, (0x60,0xA0,0xE0) gives 8'b00101111 and (0xFF,0xFF,0xFF) saturates to 8'b00111111.
REQ-035 Hold ready_in=0 and push 3 pixels -> ready_out low after 2 pixels are accepted; release -> bytes 0, 1, 2 emerge in order with addresses 0, 1, 2.
REQ-036 WIDTH=4, HEIGHT=2: stream 9 pixels -> addresses 0..7 then 0, and frame_done_out pulses once after address 7.
REQ-037 Mid-frame at address 5, push a pixel with sof_in=1 -> that byte has addr_out=0 and the next has addr_out=1.
REQ-038 Assert reset with FIFO full -> valid_out=0 next cycle, and the next accepted pixel gets addr_out=0.
